// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch + R-format ALU sequencer: Moore strobes per T-state, 6 cycles/instr with ready memory.
// Stalls in T1W while mem_ready is low and faults after MEM_TIMEOUT wait cycles; run is honoured only at instruction boundaries.
module alu_instr_sequencer #(
  parameter int          NREGS       = 16,
  parameter int          OPC_W       = 5,
  parameter logic [31:0] RFMT_MASK   = 32'h0000_7FFF,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir_value,
  output logic             pc_out,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             z_in,
  output logic             zlo_out,
  output logic             pc_in,
  output logic             mem_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic [OPC_W-1:0] alu_op,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_V    = WC_W'(MEM_TIMEOUT);
  localparam logic [4:0]      NREGS_V = 5'(NREGS);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [OPC_W-1:0] opcode;
  logic [3:0]       ra, rb, rc;
  logic             legal_op, legal;
  logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
  logic [WC_W-1:0]  wcnt_inc;
  logic             unused_ir;

  assign opcode    = ir_value[31 -: OPC_W];
  assign ra        = ir_value[26:23];
  assign rb        = ir_value[22:19];
  assign rc        = ir_value[18:15];
  assign unused_ir = ^ir_value[14:0];

  // Register fields are always 4 bits wide; indices at or above NREGS are illegal.
  assign legal_op = |(RFMT_MASK & (32'd1 << opcode));
  assign legal    = legal_op && ({1'b0, ra} < NREGS_V) && ({1'b0, rb} < NREGS_V)
                    && ({1'b0, rc} < NREGS_V);

  assign ra_oh    = NREGS'(1) << ra;
  assign rb_oh    = NREGS'(1) << rb;
  assign rc_oh    = NREGS'(1) << rc;
  assign wcnt_inc = wcnt_q + WC_W'(1);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    retired_d  = retired_q;
    pc_out     = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    z_in       = 1'b0;
    zlo_out    = 1'b0;
    pc_in      = 1'b0;
    mem_read   = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    alu_op     = '0;
    reg_in     = '0;
    reg_out    = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        zlo_out  = 1'b1;
        pc_in    = 1'b1;
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        state_d  = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        // PC was already loaded in T1, so only the memory strobes are held here.
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ready) begin
          state_d = S_T2;
          wcnt_d  = '0;
        end else if (wcnt_inc == TO_V) begin
          state_d = S_FAULT;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_inc;
        end
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (legal) begin
          reg_out = rb_oh;
          y_in    = 1'b1;
          state_d = S_T4;
        end else begin
          illegal = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        reg_out = rc_oh;
        z_in    = 1'b1;
        alu_op  = opcode;
        state_d = S_T5;
      end
      S_T5: begin
        zlo_out    = 1'b1;
        reg_in     = ra_oh;
        instr_done = 1'b1;
        retired_d  = retired_q + CNT_W'(1);
        state_d    = run ? S_T0 : S_IDLE;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench: each instruction is expanded from the datapath rules into its expected strobe trace.
// Configuration: NREGS=8, MEM_TIMEOUT=8, CNT_W=8 so register-range, timeout and wrap cases stay short.
module tb_alu_instr_sequencer;

  localparam int          NR   = 8;
  localparam int          TO   = 8;
  localparam int          CW   = 8;
  localparam logic [31:0] MASK = 32'h0000_7FFF;

  logic          clock = 1'b0;
  logic          clear, run, mem_ready;
  logic [31:0]   ir_value;
  logic          pc_out, inc_pc, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in;
  logic          mdr_out, ir_in, y_in, busy, instr_done, illegal, fault;
  logic [4:0]    alu_op;
  logic [NR-1:0] reg_in, reg_out;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic busy, fault, illegal, instr_done;
    logic pc_out, inc_pc, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in;
    logic [4:0]    alu_op;
    logic [NR-1:0] reg_in;
    logic [NR-1:0] reg_out;
  } obs_t;

  obs_t obs;
  assign obs = {busy, fault, illegal, instr_done, pc_out, inc_pc, mar_in, z_in, zlo_out,
                pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, alu_op, reg_in, reg_out};

  alu_instr_sequencer #(
    .NREGS(NR), .OPC_W(5), .RFMT_MASK(MASK), .MEM_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir_value(ir_value),
    .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in), .z_in(z_in), .zlo_out(zlo_out),
    .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .alu_op(alu_op), .reg_in(reg_in), .reg_out(reg_out), .busy(busy),
    .instr_done(instr_done), .illegal(illegal), .fault(fault), .retired(retired)
  );

  always #5 clock = ~clock;

  int            vectors    = 0;
  int            miscompares = 0;
  logic [CW-1:0] model_ret  = '0;
  bit            at_t0      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    obs_t e;
    e = '0;
    chk(tag, 64'(obs), 64'(e));
  endtask

  // Bring the sequencer from IDLE into T0 if the last instruction left it idle.
  task automatic ensure_t0();
    if (!at_t0) begin
      chk_idle("idle");
      run = 1'b1;
      tick();
      at_t0 = 1'b1;
    end
  endtask

  // Entered with the sequencer in T0; plays one instruction through and checks every cycle.
  task automatic do_instr(input logic [31:0] ir, input int nwait, input bit run_next,
                          input bit clr_t4);
    obs_t       e;
    logic [4:0] op;
    int         ra, rb, rc;
    bit         lg;
    op = ir[31:27];
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    lg = MASK[op] && ra < NR && rb < NR && rc < NR;
    ir_value = ir;

    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    chk("T0", 64'(obs), 64'(e));
    mem_ready = 1'($urandom);
    tick();

    e = '0; e.busy = 1; e.zlo_out = 1; e.pc_in = 1; e.mem_read = 1; e.mdr_in = 1;
    chk("T1", 64'(obs), 64'(e));
    mem_ready = (nwait == 0);
    tick();
    for (int i = 1; i <= nwait; i++) begin
      e = '0; e.busy = 1; e.mem_read = 1; e.mdr_in = 1;
      chk("T1W", 64'(obs), 64'(e));
      mem_ready = (i == nwait);
      tick();
    end
    mem_ready = 1'($urandom);

    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
    chk("T2", 64'(obs), 64'(e));
    run = run_next;
    tick();

    e = '0; e.busy = 1;
    if (lg) begin
      e.reg_out = NR'(1) << rb;
      e.y_in    = 1;
    end else begin
      e.illegal = 1;
    end
    chk("T3", 64'(obs), 64'(e));
    tick();
    if (!lg) begin
      chk("ret_ill", 64'(retired), 64'(model_ret));
      at_t0 = run_next;
      return;
    end

    e = '0; e.busy = 1; e.reg_out = NR'(1) << rc; e.z_in = 1; e.alu_op = op;
    chk("T4", 64'(obs), 64'(e));
    if (clr_t4) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_ret = '0;
      chk_idle("clr_idle");
      chk("clr_ret", 64'(retired), 64'(model_ret));
      run   = 1'b0;
      tick();
      chk_idle("clr_stay");
      at_t0 = 1'b0;
      return;
    end
    tick();

    e = '0; e.busy = 1; e.zlo_out = 1; e.reg_in = NR'(1) << ra; e.instr_done = 1;
    chk("T5", 64'(obs), 64'(e));
    tick();
    model_ret = model_ret + 1'b1;
    chk("ret", 64'(retired), 64'(model_ret));
    at_t0 = run_next;
  endtask

  function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  initial begin
    obs_t e;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir_value = '0;
    tick();
    tick();
    chk_idle("rst_idle");
    chk("rst_ret", 64'(retired), 64'(model_ret));
    clear = 1'b0;
    tick();
    chk_idle("idle_norun");

    // Basic ALU op, waited fetch, illegal opcode, out-of-range register, run drop.
    ensure_t0();
    do_instr(32'h2891_8000, 0, 1'b1, 1'b0);
    do_instr(mk_ir(3, 4, 5, 6), 3, 1'b1, 1'b0);
    do_instr(32'hF800_0000, 0, 1'b1, 1'b0);
    do_instr(mk_ir(5, 9, 1, 2), 0, 1'b1, 1'b0);
    do_instr(mk_ir(7, 2, 2, 2), 1, 1'b0, 1'b0);
    chk_idle("run_drop");
    run = 1'b0;
    tick();
    chk_idle("run_drop2");

    // Retire a couple, then clear in T4 must zero the count.
    ensure_t0();
    do_instr(mk_ir(1, 1, 2, 3), 0, 1'b1, 1'b0);
    do_instr(mk_ir(2, 0, 7, 7), TO - 1, 1'b1, 1'b0);
    do_instr(mk_ir(4, 5, 6, 7), 0, 1'b1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      int op;
      op = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(15, 31));
      ensure_t0();
      do_instr(mk_ir(op, $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8)),
               $urandom_range(0, 3) == 0 ? int'($urandom_range(1, TO - 1)) : 0,
               $urandom_range(0, 9) != 0, 1'b0);
    end

    // Run the counter up to its top value and across the wrap.
    while (model_ret != {CW{1'b1}}) begin
      ensure_t0();
      do_instr(mk_ir($urandom_range(0, 14), 1, 2, 3), 0, 1'b1, 1'b0);
    end
    ensure_t0();
    do_instr(mk_ir(6, 3, 3, 0), 0, 1'b1, 1'b0);
    chk("wrap", 64'(retired), 64'(0));

    // Memory never answers: TO wait cycles then a sticky fault.
    ensure_t0();
    ir_value = mk_ir(1, 1, 1, 1);
    tick();
    mem_ready = 1'b0;
    e = '0; e.busy = 1; e.zlo_out = 1; e.pc_in = 1; e.mem_read = 1; e.mdr_in = 1;
    chk("f_T1", 64'(obs), 64'(e));
    tick();
    for (int i = 0; i < TO; i++) begin
      e = '0; e.busy = 1; e.mem_read = 1; e.mdr_in = 1;
      chk("f_T1W", 64'(obs), 64'(e));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      e = '0; e.fault = 1;
      chk("fault", 64'(obs), 64'(e));
      mem_ready = 1'($urandom);
      run = 1'b1;
      tick();
    end
    chk("f_ret", 64'(retired), 64'(model_ret));
    clear = 1'b1;
    run   = 1'b0;
    tick();
    clear = 1'b0;
    model_ret = '0;
    chk_idle("f_clr");
    chk("f_clr_ret", 64'(retired), 64'(model_ret));
    at_t0 = 1'b0;
    ensure_t0();
    do_instr(32'h2891_8000, 0, 1'b0, 1'b0);
    chk_idle("end_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
